// File: rtl/stack_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_exec_unit
// Brief    : Three-cycle data-stack execution unit; TOS held in a register,
//            deeper entries in a synchronous-read RAM, sticky error flags.
// Revision : 1.0
// ============================================================================
module stack_exec_unit #(
    parameter int WIDTH_DATA = 16,
    parameter int AWIDTH     = 5,
    parameter int OPC_W      = 5,
    parameter bit SIGN_EXT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_DATA-1:0] instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  err_clr,
    output logic [WIDTH_DATA-1:0] tos,
    output logic [AWIDTH:0]       depth,
    output logic                  empty,
    output logic                  full,
    output logic                  done,
    output logic                  err_under,
    output logic                  err_over,
    output logic                  err_illegal
);

    localparam int IMM_W       = WIDTH_DATA - OPC_W;
    localparam int C_RAM_DEPTH = 2**AWIDTH;

    localparam logic [AWIDTH:0]   C_FULL  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   C_D_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0]   C_D_TWO = (AWIDTH+1)'(2);
    localparam logic [AWIDTH-1:0] C_A_ONE = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] C_A_TWO = AWIDTH'(2);

    localparam logic [OPC_W-1:0] C_OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] C_OP_PUSH = OPC_W'(1);
    localparam logic [OPC_W-1:0] C_OP_POP  = OPC_W'(2);
    localparam logic [OPC_W-1:0] C_OP_DUP  = OPC_W'(3);
    localparam logic [OPC_W-1:0] C_OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] C_OP_SUB  = OPC_W'(5);
    localparam logic [OPC_W-1:0] C_OP_AND  = OPC_W'(6);
    localparam logic [OPC_W-1:0] C_OP_OR   = OPC_W'(7);
    localparam logic [OPC_W-1:0] C_OP_XOR  = OPC_W'(8);
    localparam logic [OPC_W-1:0] C_OP_SWAP = OPC_W'(9);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    state_t                r_state;
    logic [OPC_W-1:0]      r_opc;
    logic [WIDTH_DATA-1:0] r_imm_ext;
    logic [WIDTH_DATA-1:0] r_tos;
    logic [WIDTH_DATA-1:0] r_nos;
    logic [AWIDTH:0]       r_depth;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_f_under;
    logic                  r_f_over;
    logic                  r_f_ill;
    logic                  r_err_under;
    logic                  r_err_over;
    logic                  r_err_ill;
    logic [WIDTH_DATA-1:0] r_ram [C_RAM_DEPTH];

    logic [IMM_W-1:0]      w_imm;
    logic [WIDTH_DATA-1:0] w_imm_ext;
    logic [WIDTH_DATA-1:0] w_alu;
    logic [WIDTH_DATA-1:0] w_tos_nxt;
    logic [AWIDTH:0]       w_depth_nxt;
    logic                  w_in_exec;
    logic                  w_is_alu;
    logic                  w_legal;
    logic                  w_need1;
    logic                  w_need2;
    logic                  w_grow;
    logic                  w_under;
    logic                  w_over;
    logic                  w_commit;
    logic                  w_ram_we;
    logic [AWIDTH-1:0]     w_rd_addr;
    logic [AWIDTH-1:0]     w_wr_addr;

    assign w_imm = instruction[IMM_W-1:0];

    generate
        if (SIGN_EXT) begin : g_sext
            assign w_imm_ext = {{OPC_W{w_imm[IMM_W-1]}}, w_imm};
        end else begin : g_zext
            assign w_imm_ext = {{OPC_W{1'b0}}, w_imm};
        end
    endgenerate

    // Legality and depth checks run in DECODE on the latched opcode
    assign w_is_alu = (r_opc >= C_OP_ADD) && (r_opc <= C_OP_XOR);
    assign w_legal  = (r_opc <= C_OP_SWAP);
    assign w_need1  = (r_opc == C_OP_POP) || (r_opc == C_OP_DUP);
    assign w_need2  = w_is_alu || (r_opc == C_OP_SWAP);
    assign w_grow   = (r_opc == C_OP_PUSH) || (r_opc == C_OP_DUP);
    assign w_under  = w_legal && ((w_need1 && (r_depth == '0)) ||
                                  (w_need2 && (r_depth < C_D_TWO)));
    assign w_over   = w_legal && w_grow && (r_depth == C_FULL);

    assign w_in_exec = (r_state == S_EXEC);
    assign w_commit  = w_in_exec && !(r_f_under || r_f_over || r_f_ill);

    // NOS lives at RAM[depth-2]; a push spills the old TOS into RAM[depth-1]
    assign w_rd_addr = r_depth[AWIDTH-1:0] - C_A_TWO;
    assign w_wr_addr = (r_opc == C_OP_SWAP) ? (r_depth[AWIDTH-1:0] - C_A_TWO)
                                            : (r_depth[AWIDTH-1:0] - C_A_ONE);
    assign w_ram_we  = w_commit && ((w_grow && (r_depth != '0)) || (r_opc == C_OP_SWAP));

    always_comb begin
        w_alu = r_tos;
        case (r_opc)
            C_OP_ADD: w_alu = r_nos + r_tos;
            C_OP_SUB: w_alu = r_nos - r_tos;
            C_OP_AND: w_alu = r_nos & r_tos;
            C_OP_OR:  w_alu = r_nos | r_tos;
            C_OP_XOR: w_alu = r_nos ^ r_tos;
            default:  w_alu = r_tos;
        endcase
    end

    always_comb begin
        w_tos_nxt   = r_tos;
        w_depth_nxt = r_depth;
        case (r_opc)
            C_OP_NOP: begin
                w_tos_nxt   = r_tos;
                w_depth_nxt = r_depth;
            end
            C_OP_PUSH: begin
                w_tos_nxt   = r_imm_ext;
                w_depth_nxt = r_depth + C_D_ONE;
            end
            C_OP_DUP: begin
                w_depth_nxt = r_depth + C_D_ONE;
            end
            C_OP_POP: begin
                w_tos_nxt   = (r_depth == C_D_ONE) ? '0 : r_nos;
                w_depth_nxt = r_depth - C_D_ONE;
            end
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_XOR: begin
                w_tos_nxt   = w_alu;
                w_depth_nxt = r_depth - C_D_ONE;
            end
            C_OP_SWAP: begin
                w_tos_nxt   = r_nos;
            end
            default: begin
                w_tos_nxt   = r_tos;
                w_depth_nxt = r_depth;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_opc       <= '0;
            r_imm_ext   <= '0;
            r_tos       <= '0;
            r_depth     <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_f_under   <= 1'b0;
            r_f_over    <= 1'b0;
            r_f_ill     <= 1'b0;
            r_err_under <= 1'b0;
            r_err_over  <= 1'b0;
            r_err_ill   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            // A flag raised in the same cycle as a clear stays set
            r_err_under <= (w_in_exec & r_f_under) | (r_err_under & ~err_clr);
            r_err_over  <= (w_in_exec & r_f_over)  | (r_err_over  & ~err_clr);
            r_err_ill   <= (w_in_exec & r_f_ill)   | (r_err_ill   & ~err_clr);
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_opc     <= instruction[WIDTH_DATA-1 -: OPC_W];
                        r_imm_ext <= w_imm_ext;
                        r_ready   <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_f_under <= w_under;
                    r_f_over  <= w_over;
                    r_f_ill   <= ~w_legal;
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_commit) begin
                        r_tos   <= w_tos_nxt;
                        r_depth <= w_depth_nxt;
                    end
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) begin
            r_nos <= r_ram[w_rd_addr];
        end
        if (w_ram_we) begin
            r_ram[w_wr_addr] <= r_tos;
        end
    end

    assign instr_ready = r_ready;
    assign tos         = r_tos;
    assign depth       = r_depth;
    assign empty       = (r_depth == '0);
    assign full        = (r_depth == C_FULL);
    assign done        = r_done;
    assign err_under   = r_err_under;
    assign err_over    = r_err_over;
    assign err_illegal = r_err_ill;

endmodule
`default_nettype wire

// File: tb/tb_stack_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_exec_unit
// Brief    : Directed and random checks of stack_exec_unit against a
//            queue-based stack model.
// Revision : 1.0
// ============================================================================
module tb_stack_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        err_clr;

    logic        instr_ready, done, empty, full, err_under, err_over, err_illegal;
    logic [15:0] tos;
    logic [5:0]  depth;

    logic        sx_ready, sx_done, sx_empty, sx_full, sx_under, sx_over, sx_ill;
    logic [15:0] sx_tos;
    logic [5:0]  sx_depth;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] stk[$];
    bit          m_under, m_over, m_ill;

    always #5 clk = ~clk;

    stack_exec_unit #(.WIDTH_DATA(16), .AWIDTH(5), .OPC_W(5), .SIGN_EXT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .err_clr(err_clr), .tos(tos), .depth(depth),
        .empty(empty), .full(full), .done(done), .err_under(err_under),
        .err_over(err_over), .err_illegal(err_illegal)
    );

    stack_exec_unit #(.WIDTH_DATA(16), .AWIDTH(5), .OPC_W(5), .SIGN_EXT(1'b1)) u_sx (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(sx_ready), .err_clr(err_clr), .tos(sx_tos), .depth(sx_depth),
        .empty(sx_empty), .full(sx_full), .done(sx_done), .err_under(sx_under),
        .err_over(sx_over), .err_illegal(sx_ill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_tos();
        return (stk.size() > 0) ? stk[stk.size()-1] : 16'h0000;
    endfunction

    task automatic model_apply(input logic [4:0] opc, input logic [10:0] imm, input bit clr);
        int          n;
        logic [15:0] a, b, r;
        bit          u, o, il;
        n = stk.size();
        u = 0; o = 0; il = 0;
        if (clr) begin
            m_under = 0; m_over = 0; m_ill = 0;
        end
        if (opc > 5'd9) begin
            il = 1;
        end else begin
            case (opc)
                5'd1: if (n == 32) o = 1; else stk.push_back({5'b0, imm});
                5'd2: if (n < 1) u = 1; else void'(stk.pop_back());
                5'd3: if (n < 1) u = 1; else if (n == 32) o = 1; else stk.push_back(stk[n-1]);
                5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                    if (n < 2) u = 1;
                    else begin
                        b = stk.pop_back();
                        a = stk.pop_back();
                        case (opc)
                            5'd4:    r = a + b;
                            5'd5:    r = a - b;
                            5'd6:    r = a & b;
                            5'd7:    r = a | b;
                            default: r = a ^ b;
                        endcase
                        stk.push_back(r);
                    end
                end
                5'd9: begin
                    if (n < 2) u = 1;
                    else begin
                        b = stk[n-1];
                        stk[n-1] = stk[n-2];
                        stk[n-2] = b;
                    end
                end
                default: ;
            endcase
        end
        m_under = m_under | u;
        m_over  = m_over  | o;
        m_ill   = m_ill   | il;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".tos"},   tos,         m_tos());
        chk({tag, ".depth"}, depth,       stk.size());
        chk({tag, ".empty"}, empty,       stk.size() == 0);
        chk({tag, ".full"},  full,        stk.size() == 32);
        chk({tag, ".eund"},  err_under,   m_under);
        chk({tag, ".eovr"},  err_over,    m_over);
        chk({tag, ".eill"},  err_illegal, m_ill);
    endtask

    // Issue one instruction; clr0/clr2 hold err_clr over the accept / commit edge
    task automatic run_op(input string tag, input logic [4:0] opc, input logic [10:0] imm,
                          input bit clr0, input bit clr2);
        int k;
        k = 0;
        while (instr_ready !== 1'b1 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".idle_rdy"}, instr_ready, 1);
        @(negedge clk);
        instruction = {opc, imm};
        instr_valid = 1'b1;
        err_clr     = clr0;
        @(posedge clk); #1;
        if (clr0) begin
            m_under = 0; m_over = 0; m_ill = 0;
        end
        instruction = 16'($urandom);
        err_clr     = 1'b0;
        chk({tag, ".busy_rdy"}, instr_ready, 0);
        chk({tag, ".done_e0"},  done, 0);
        @(posedge clk); #1;
        chk({tag, ".done_e1"},  done, 0);
        err_clr = clr2;
        @(posedge clk); #1;
        err_clr     = 1'b0;
        instr_valid = 1'b0;
        model_apply(opc, imm, clr2);
        chk({tag, ".done_e2"},  done, 1);
        chk({tag, ".rdy_e2"},   instr_ready, 1);
        check_state(tag);
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_under = 0; m_over = 0; m_ill = 0;
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        stk.delete();
        m_under = 0; m_over = 0; m_ill = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [4:0] opc;
        int         r;

        reset = 1'b0; instruction = '0; instr_valid = 1'b0; err_clr = 1'b0;
        m_under = 0; m_over = 0; m_ill = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", instr_ready, 1);
        chk("rst.done",  done, 0);
        check_state("rst");
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset while a PUSH_I is in EXEC
        run_op("pre", 5'd1, 11'd3, 0, 0);
        @(negedge clk);
        instruction = {5'd1, 11'd5};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        stk.delete();
        m_under = 0; m_over = 0; m_ill = 0;
        chk("arst.ready", instr_ready, 1);
        chk("arst.done",  done, 0);
        check_state("arst");
        @(negedge clk);
        reset = 1'b1;

        run_op("add.p5", 5'd1, 11'd5, 0, 0);
        run_op("add.p2", 5'd1, 11'd2, 0, 0);
        run_op("add",    5'd4, 11'd0, 0, 0);
        chk("add.tos7", tos, 16'd7);

        run_op("sub.p2", 5'd1, 11'd2, 0, 0);
        run_op("sub.p5", 5'd1, 11'd5, 0, 0);
        run_op("sub",    5'd5, 11'd0, 0, 0);
        chk("sub.wrap", tos, 16'hFFFD);
        run_op("swap",   5'd9, 11'd0, 0, 0);
        chk("swap.tos", tos, 16'd7);
        run_op("pop1",   5'd2, 11'd0, 0, 0);
        run_op("pop2",   5'd2, 11'd0, 0, 0);

        run_op("und.add", 5'd4, 11'd0, 0, 0);
        chk("und.flag", err_under, 1);
        clr_pulse("und.clr");
        run_op("und.setwins", 5'd2, 11'd0, 0, 1);
        run_op("und.dup",     5'd3, 11'd0, 1, 0);
        clr_pulse("und.clr2");

        for (int i = 0; i < 32; i++) begin
            run_op("fill", 5'd1, 11'($urandom), 0, 0);
        end
        run_op("ovr.push", 5'd1, 11'd1, 0, 0);
        chk("ovr.flag", err_over, 1);
        run_op("ovr.dup",  5'd3, 11'd0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_op("drain", 5'($urandom_range(2, 9)), 11'd0, 0, 0);
        end

        do_reset();
        run_op("sx.push", 5'd1, 11'h7FF, 0, 0);
        chk("sx.tos", sx_tos, 16'hFFFF);
        run_op("ill.31", 5'd31, 11'h123, 1, 0);
        chk("ill.flag", err_illegal, 1);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r <= 9)       opc = 5'(r);
            else if (r <= 12) opc = 5'd1;
            else              opc = 5'($urandom_range(10, 31));
            run_op("rnd", opc, 11'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
